// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and TX state encoding; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DATA_BITS            = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte/strobe request side and serial/status side of the UART transmitter
interface uart_tx_if;
   import uart_pkg::*;

   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_byte;
   logic                 tx_data;
   logic                 tx_busy;
   logic                 tx_down;

   modport master (output tx_start, output tx_byte,
                   input  tx_data, input tx_busy, input tx_down);
   modport slave  (input  tx_start, input tx_byte,
                   output tx_data, output tx_busy, output tx_down);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; tick pulses on the wrap, counter held clear while en=0
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int                 CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign tick   = en & w_wrap;

   always_ff @(posedge clk) begin
      if (rst || !en || w_wrap)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8 data bits LSB first, 1 or 2 stop bits
// UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic      clk,
   input  logic      rst,
   uart_tx_if.slave  tx_if
);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   logic [2:0]           r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_tx_data;
   logic                 r_busy;
   logic                 r_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif
   logic                 w_tick;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (r_busy),
      .tick (w_tick)
   );

   assign tx_if.tx_data = r_tx_data;
   assign tx_if.tx_busy = r_busy;
   assign tx_if.tx_down = r_done;

   // r_tx_data is loaded with the level of the state being entered, so it changes exactly on bit boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx_data <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx_data <= 1'b1;
               if (tx_if.tx_start && !r_busy) begin
                  r_shift   <= tx_if.tx_byte;
`ifdef UART_TX_PARITY_EN
                  r_parity  <= even_parity(tx_if.tx_byte);
`endif
                  r_state   <= ST_START;
                  r_tx_data <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_idx <= '0;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state   <= ST_DATA;
                  r_tx_data <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == LAST_DATA) begin
                     r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     r_state   <= ST_PARITY;
                     r_tx_data <= r_parity;
`else
                     r_state   <= ST_STOP;
                     r_tx_data <= 1'b1;
`endif
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_tx_data <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_state   <= ST_STOP;
                  r_tx_data <= 1'b1;
                  r_bit_idx <= '0;
               end
            end
`endif
            ST_STOP: begin
               r_tx_data <= 1'b1;
               if (w_tick) begin
                  if (r_bit_idx == LAST_STOP) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
               r_tx_data <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter: 8 data bits, LSB first, no parity by default, 1 or 2 stop bits. It is the transmit-side counterpart of the existing 8N1 receiver and uses the same 434-clock bit period. It sits between the system logic, which presents a byte plus a start strobe, and the TX pin. It reports busy and a one-cycle done pulse.

Parameters:
- CLKS_PER_BIT, 434: clocks per bit period; legal range 2..1023.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- tx_start  input  1  request to send tx_byte; sampled every cycle.
- tx_byte  input  8  byte to send; sampled only on the accept cycle.
- tx_data  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after accept until the frame ends.
- tx_down  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (rst=1 at a clk edge), next-cycle values: tx_data=1, tx_busy=0, tx_down=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: the line returns high on the next edge, the frame is abandoned, and no tx_down is issued.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - tx_data=1.
  - If tx_start=1 and tx_busy=0, latch tx_byte into the shift register and go to START.
  - tx_start while busy is ignored; nothing is queued.
- START: tx_data=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx_data = shift[0].
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and bit_idx increments.
  - After bit_idx=7 completes, go to PARITY (if enabled) or STOP.
- STOP:
  - tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - tx_down=1 for exactly the first IDLE cycle.
- Latency:
  - tx_data falls on the first clock edge after the accept edge.
  - With default parameters, the frame spans 10*434=4340 cycles from the first low cycle to the first IDLE cycle.
- tx_busy:
  - 1 in START, DATA, PARITY and STOP; 0 in IDLE, including the tx_down cycle.
  - A tx_start asserted during the tx_down cycle is accepted, giving back-to-back frames with no idle bit beyond the stop bit(s).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Cleared on accept, and held at 0 in IDLE.
  - Bit boundaries occur only on the wrap.
  - Counter width is $clog2(CLKS_PER_BIT); bit_idx is 3 bits.
- tx_byte changes after the accept cycle have no effect on the frame in flight.
- tx_data is driven from a register, so the pin is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits even parity, the XOR of the 8 latched bits, for CLKS_PER_BIT cycles.
  - The frame becomes 11 bits (4774 cycles by default).
- Undefined: the PARITY state, its logic and its encoding are absent, and the frame is 8N1 (or 8N2).

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits);
  - DEFAULT_CLKS_PER_BIT=434;
  - DATA_BITS=8.
  The receiver and transmitter both import it.
- Sub-module uart_baud_gen:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, en.
  - Output tick: one-cycle pulse on the counter wrap; the counter clears when en=0.
  - uart_tx instantiates it with en=tx_busy.

Test Plan:
- Send 0x55 after reset (tx_start pulse for 1 cycle) -> line samples at each bit centre read 0,1,0,1,0,1,0,1,0,1. tx_down fires once at 4340 cycles after the falling edge. tx_busy is high exactly 4340 cycles.
- Send 0xA3 -> centre samples 0,1,1,0,0,0,1,0,1,1 (start, LSB first, stop). Each bit is measured to be exactly 434 cycles wide.
- Send 0x0F, then hold tx_start=1 with tx_byte=0xFF for 2000 cycles mid-frame -> 0x0F is sent unaltered and no second frame starts. The line idles high after tx_down once tx_start drops before then.
- Back-to-back: 0x12 then 0x34, with the second tx_start asserted in the tx_down cycle -> the second start bit begins on the next edge, with no extra idle cycles. A loop-back through the receiver yields po_data 0x12 then 0x34.
- Reset asserted at cycle 1500 of a 0x00 frame -> tx_data=1 on the next edge and tx_busy=0. No tx_down is issued. A new tx_start 10 cycles later produces a clean frame.
- With UART_TX_PARITY_EN defined: send 0x07 -> parity bit is 1 and the frame lasts 4774 cycles. Send 0x03 -> parity bit is 0.
